// File: rtl/ycr_tapc_os_if.sv
// Chain interface between the oversampled TAP controller and the Debug Module Interface.
// master = TAP controller side, slave = DMI side.
interface ycr_tapc_os_if;
    logic       tapc2dmi_ch_sel_o;
    logic [1:0] tapc2dmi_ch_id_o;
    logic       tapc2dmi_ch_capture_o;
    logic       tapc2dmi_ch_shift_o;
    logic       tapc2dmi_ch_update_o;
    logic       tapc2dmi_ch_tdi_o;
    logic       dmi2tapc_ch_tdo_i;

    modport master (
        output tapc2dmi_ch_sel_o, tapc2dmi_ch_id_o, tapc2dmi_ch_capture_o,
               tapc2dmi_ch_shift_o, tapc2dmi_ch_update_o, tapc2dmi_ch_tdi_o,
        input  dmi2tapc_ch_tdo_i
    );

    modport slave (
        input  tapc2dmi_ch_sel_o, tapc2dmi_ch_id_o, tapc2dmi_ch_capture_o,
               tapc2dmi_ch_shift_o, tapc2dmi_ch_update_o, tapc2dmi_ch_tdi_o,
        output dmi2tapc_ch_tdo_i
    );
endinterface

// File: rtl/ycr_tapc_os.sv
// Oversampled IEEE 1149.1 TAP controller on the core clock, driving the DMI chain interface.
// TCK edges are found by comparing the synchronised TCK with its registered copy.
//
// state       | meaning
// ST_TLR      | Test-Logic-Reset, IR held at IDCODE
// ST_RTI      | Run-Test/Idle
// ST_SEL_DR   | Select-DR-Scan
// ST_CAP_DR   | Capture-DR: load IDCODE / clear bypass / chain capture pulse
// ST_SH_DR    | Shift-DR: shift selected DR, TDO driven
// ST_EX1_DR   | Exit1-DR
// ST_PAU_DR   | Pause-DR
// ST_EX2_DR   | Exit2-DR
// ST_UPD_DR   | Update-DR: chain update pulse on TCK fall
// ST_SEL_IR   | Select-IR-Scan
// ST_CAP_IR   | Capture-IR: ir_shift <= 5'b00001
// ST_SH_IR    | Shift-IR: shift IR, TDO driven
// ST_EX1_IR   | Exit1-IR
// ST_PAU_IR   | Pause-IR
// ST_EX2_IR   | Exit2-IR
// ST_UPD_IR   | Update-IR: IR loaded on TCK fall
module ycr_tapc_os #(
    parameter logic [31:0] YCR_TAP_IDCODE = 32'hDEB11001
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tck_sync_i,
    input  logic                 tms_sync_i,
    input  logic                 tdi_sync_i,
    output logic                 tdo_o,
    output logic                 tdo_en_o,
    ycr_tapc_os_if.master        dmi
);
    localparam int unsigned YCR_TAP_IR_WIDTH = 5;

    localparam logic [YCR_TAP_IR_WIDTH-1:0] IR_IDCODE = 5'h01;
    localparam logic [YCR_TAP_IR_WIDTH-1:0] IR_DTMCS  = 5'h10;
    localparam logic [YCR_TAP_IR_WIDTH-1:0] IR_DMI    = 5'h11;

    typedef enum logic [3:0] {
        ST_TLR, ST_RTI,
        ST_SEL_DR, ST_CAP_DR, ST_SH_DR, ST_EX1_DR, ST_PAU_DR, ST_EX2_DR, ST_UPD_DR,
        ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR, ST_PAU_IR, ST_EX2_IR, ST_UPD_IR
    } tap_state_e;

    tap_state_e                  state_q, state_d;
    logic                        tck_q;
    logic [YCR_TAP_IR_WIDTH-1:0] ir_q;
    logic [YCR_TAP_IR_WIDTH-1:0] ir_shift_q;
    logic [31:0]                 idcode_sr_q;
    logic                        bypass_q;
    logic                        tdo_q, tdo_en_q;
    logic                        capture_q, shift_q, update_q, ch_tdi_q;
    logic                        rise, fall;
    logic                        ch_sel, is_idcode;

    assign rise      = tck_sync_i & ~tck_q;
    assign fall      = ~tck_sync_i & tck_q;
    assign ch_sel    = (ir_q == IR_DTMCS) || (ir_q == IR_DMI);
    assign is_idcode = (ir_q == IR_IDCODE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_TLR:    state_d = tms_sync_i ? ST_TLR    : ST_RTI;
            ST_RTI:    state_d = tms_sync_i ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: state_d = tms_sync_i ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: state_d = tms_sync_i ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  state_d = tms_sync_i ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: state_d = tms_sync_i ? ST_UPD_DR : ST_PAU_DR;
            ST_PAU_DR: state_d = tms_sync_i ? ST_EX2_DR : ST_PAU_DR;
            ST_EX2_DR: state_d = tms_sync_i ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: state_d = tms_sync_i ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: state_d = tms_sync_i ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: state_d = tms_sync_i ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  state_d = tms_sync_i ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: state_d = tms_sync_i ? ST_UPD_IR : ST_PAU_IR;
            ST_PAU_IR: state_d = tms_sync_i ? ST_EX2_IR : ST_PAU_IR;
            ST_EX2_IR: state_d = tms_sync_i ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: state_d = tms_sync_i ? ST_SEL_DR : ST_RTI;
            default:   state_d = ST_TLR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_TLR;
            tck_q       <= 1'b0;
            ir_q        <= IR_IDCODE;
            ir_shift_q  <= '0;
            idcode_sr_q <= '0;
            bypass_q    <= 1'b0;
            tdo_q       <= 1'b0;
            tdo_en_q    <= 1'b0;
            capture_q   <= 1'b0;
            shift_q     <= 1'b0;
            update_q    <= 1'b0;
            ch_tdi_q    <= 1'b0;
        end else begin
            tck_q     <= tck_sync_i;
            capture_q <= 1'b0;
            shift_q   <= 1'b0;
            update_q  <= 1'b0;

            // Rise-cycle actions act on the state being left.
            if (rise) begin
                state_q <= state_d;
                unique case (state_q)
                    ST_CAP_IR: ir_shift_q <= 5'b00001;
                    ST_SH_IR:  ir_shift_q <= {tdi_sync_i, ir_shift_q[YCR_TAP_IR_WIDTH-1:1]};
                    ST_CAP_DR: begin
                        idcode_sr_q <= YCR_TAP_IDCODE;
                        bypass_q    <= 1'b0;
                        capture_q   <= ch_sel;
                    end
                    ST_SH_DR: begin
                        idcode_sr_q <= {tdi_sync_i, idcode_sr_q[31:1]};
                        bypass_q    <= tdi_sync_i;
                        shift_q     <= ch_sel;
                        ch_tdi_q    <= tdi_sync_i;
                    end
                    default: ;
                endcase
            end

            // Fall cycles drive TDO and commit updates, giving the chain time to settle.
            if (fall) begin
                tdo_en_q <= (state_q == ST_SH_IR) || (state_q == ST_SH_DR);
                unique case (state_q)
                    ST_SH_IR:  tdo_q <= ir_shift_q[0];
                    ST_SH_DR: begin
                        if (ch_sel)         tdo_q <= dmi.dmi2tapc_ch_tdo_i;
                        else if (is_idcode) tdo_q <= idcode_sr_q[0];
                        else                tdo_q <= bypass_q;
                    end
                    ST_UPD_IR: ir_q     <= ir_shift_q;
                    ST_UPD_DR: update_q <= ch_sel;
                    default: ;
                endcase
            end

            if (state_q == ST_TLR) begin
                ir_q <= IR_IDCODE;
            end
        end
    end

    assign tdo_o    = tdo_q;
    assign tdo_en_o = tdo_en_q;

    assign dmi.tapc2dmi_ch_sel_o     = ch_sel;
    assign dmi.tapc2dmi_ch_id_o      = (ir_q == IR_DTMCS) ? 2'd1 :
                                       (ir_q == IR_DMI)   ? 2'd2 : 2'd0;
    assign dmi.tapc2dmi_ch_capture_o = capture_q;
    assign dmi.tapc2dmi_ch_shift_o   = shift_q;
    assign dmi.tapc2dmi_ch_update_o  = update_q;
    assign dmi.tapc2dmi_ch_tdi_o     = ch_tdi_q;
endmodule

// File: tb/tb_ycr_tapc_os.sv
// Directed bench for ycr_tapc_os: TAP reset, IDCODE/IR/DMI/bypass scans and reset mid-scan.
module tb_ycr_tapc_os;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tck_r = 1'b0, tms_r = 1'b1, tdi_r = 1'b0;
    logic tdo_o, tdo_en_o;
    int   checks = 0;
    int   errors = 0;

    ycr_tapc_os_if dmi_if ();

    ycr_tapc_os dut (
        .clk        (clk),
        .rst        (rst),
        .tck_sync_i (tck_r),
        .tms_sync_i (tms_r),
        .tdi_sync_i (tdi_r),
        .tdo_o      (tdo_o),
        .tdo_en_o   (tdo_en_o),
        .dmi        (dmi_if)
    );

    always #5 clk = ~clk;

    // Pulse monitor: running counts, width violations and a history of ch_tdi at shift pulses.
    int          cap_cnt = 0, sh_cnt = 0, upd_cnt = 0, wide_cnt = 0;
    logic        cap_p = 1'b0, sh_p = 1'b0, upd_p = 1'b0;
    logic [63:0] tdi_hist = '0;

    always @(negedge clk) begin
        if (dmi_if.tapc2dmi_ch_capture_o) cap_cnt++;
        if (dmi_if.tapc2dmi_ch_update_o)  upd_cnt++;
        if (dmi_if.tapc2dmi_ch_shift_o) begin
            sh_cnt++;
            tdi_hist = {dmi_if.tapc2dmi_ch_tdi_o, tdi_hist[63:1]};
        end
        if ((cap_p && dmi_if.tapc2dmi_ch_capture_o) || (sh_p && dmi_if.tapc2dmi_ch_shift_o) ||
            (upd_p && dmi_if.tapc2dmi_ch_update_o)) wide_cnt++;
        cap_p = dmi_if.tapc2dmi_ch_capture_o;
        sh_p  = dmi_if.tapc2dmi_ch_shift_o;
        upd_p = dmi_if.tapc2dmi_ch_update_o;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tck_cycle(input logic tms, input logic tdi, input logic dtdo,
                             output logic tdo, output logic en);
        @(negedge clk);
        tms_r = tms;
        tdi_r = tdi;
        dmi_if.dmi2tapc_ch_tdo_i = dtdo;
        tck_r = 1'b1;
        repeat (3) @(negedge clk);
        tck_r = 1'b0;
        repeat (3) @(negedge clk);
        tdo = tdo_o;
        en  = tdo_en_o;
    endtask

    // RTI -> scan of n bits -> RTI. dout bit k is tdo after the k-th fall in Shift.
    task automatic do_scan(input logic is_ir, input int n, input logic [63:0] din,
                           input logic [63:0] pat, output logic [63:0] dout, output int en_cnt);
        logic t, e;
        dout = '0;
        en_cnt = 0;
        tck_cycle(1'b1, 1'b0, 1'b0, t, e); en_cnt += int'(e);
        if (is_ir) begin
            tck_cycle(1'b1, 1'b0, 1'b0, t, e); en_cnt += int'(e);
        end
        tck_cycle(1'b0, 1'b0, 1'b0, t, e); en_cnt += int'(e);
        tck_cycle(1'b0, 1'b0, pat[0], t, e); en_cnt += int'(e);
        dout[0] = t;
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i], pat[(i + 1) % 64], t, e);
            en_cnt += int'(e);
            if (i < n - 1) dout[i + 1] = t;
        end
        tck_cycle(1'b1, 1'b0, 1'b0, t, e); en_cnt += int'(e);
        tck_cycle(1'b0, 1'b0, 1'b0, t, e); en_cnt += int'(e);
    endtask

    initial begin
        logic [63:0] dout;
        logic [63:0] din, pat;
        int          en_cnt;
        int          c0, s0, u0;
        logic        t, e;

        dmi_if.dmi2tapc_ch_tdo_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tdo",    64'(tdo_o), 64'h0);
        check("rst_tdo_en", 64'(tdo_en_o), 64'h0);
        check("rst_ch_sel", 64'(dmi_if.tapc2dmi_ch_sel_o), 64'h0);
        rst = 1'b0;

        // Load DMI_ACCESS, then 5x TMS=1 must return IR to IDCODE via Test-Logic-Reset.
        tck_cycle(1'b0, 1'b0, 1'b0, t, e);
        do_scan(1'b1, 5, 64'h11, 64'h0, dout, en_cnt);
        check("pre_tlr_ch_sel", 64'(dmi_if.tapc2dmi_ch_sel_o), 64'h1);
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, 1'b0, t, e);
        check("tlr_ch_sel", 64'(dmi_if.tapc2dmi_ch_sel_o), 64'h0);
        check("tlr_ch_id",  64'(dmi_if.tapc2dmi_ch_id_o), 64'h0);
        check("tlr_tdo_en", 64'(tdo_en_o), 64'h0);
        tck_cycle(1'b0, 1'b0, 1'b0, t, e);

        do_scan(1'b0, 32, 64'h0, 64'h0, dout, en_cnt);
        check("idcode_dr", dout, 64'hDEB11001);
        check("idcode_en", 64'(en_cnt), 64'd32);

        do_scan(1'b1, 5, 64'h11, 64'h0, dout, en_cnt);
        check("ir_capture", dout, 64'h01);
        check("ir_en",      64'(en_cnt), 64'd5);
        check("dmi_ch_sel", 64'(dmi_if.tapc2dmi_ch_sel_o), 64'h1);
        check("dmi_ch_id",  64'(dmi_if.tapc2dmi_ch_id_o), 64'h2);

        c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
        din = 64'h0000_015A_C3E7_9D21;
        pat = 64'h0000_00B4_0F96_3C5A;
        do_scan(1'b0, 41, din, pat, dout, en_cnt);
        check("dmi_tdo",     dout & 64'h1FF_FFFF_FFFF, 64'h0B4_0F96_3C5A);
        check("dmi_en",      64'(en_cnt), 64'd41);
        check("dmi_capture", 64'(cap_cnt - c0), 64'd1);
        check("dmi_shift",   64'(sh_cnt - s0), 64'd41);
        check("dmi_update",  64'(upd_cnt - u0), 64'd1);
        check("pulse_width", 64'(wide_cnt), 64'd0);
        check("dmi_ch_tdi",  tdi_hist >> 23, 64'h15A_C3E7_9D21);

        do_scan(1'b1, 5, 64'h10, 64'h0, dout, en_cnt);
        check("dtmcs_ch_id", 64'(dmi_if.tapc2dmi_ch_id_o), 64'h1);

        do_scan(1'b1, 5, 64'h05, 64'h0, dout, en_cnt);
        check("undef_ch_sel", 64'(dmi_if.tapc2dmi_ch_sel_o), 64'h0);
        check("undef_ch_id",  64'(dmi_if.tapc2dmi_ch_id_o), 64'h0);
        c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
        do_scan(1'b0, 8, 64'hA5, 64'hFF, dout, en_cnt);
        check("bypass_tdo",    dout, 64'h4A);
        check("bypass_pulses", 64'((cap_cnt - c0) + (sh_cnt - s0) + (upd_cnt - u0)), 64'd0);

        // Reset in the middle of a DMI_ACCESS Shift-DR.
        do_scan(1'b1, 5, 64'h11, 64'h0, dout, en_cnt);
        tck_cycle(1'b1, 1'b0, 1'b0, t, e);
        tck_cycle(1'b0, 1'b0, 1'b0, t, e);
        tck_cycle(1'b0, 1'b0, 1'b1, t, e);
        for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1, 1'b1, t, e);
        check("mid_scan_en", 64'(tdo_en_o), 64'h1);
        u0 = upd_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("mrst_tdo",    64'(tdo_o), 64'h0);
        check("mrst_tdo_en", 64'(tdo_en_o), 64'h0);
        check("mrst_ch_sel", 64'(dmi_if.tapc2dmi_ch_sel_o), 64'h0);
        check("mrst_ch_id",  64'(dmi_if.tapc2dmi_ch_id_o), 64'h0);
        check("mrst_pulses", 64'({dmi_if.tapc2dmi_ch_capture_o, dmi_if.tapc2dmi_ch_shift_o,
                                  dmi_if.tapc2dmi_ch_update_o}), 64'h0);
        rst = 1'b0;
        tms_r = 1'b1;
        repeat (4) @(negedge clk);
        check("mrst_no_update", 64'(upd_cnt - u0), 64'd0);
        tck_cycle(1'b0, 1'b0, 1'b0, t, e);
        do_scan(1'b0, 32, 64'h0, 64'h0, dout, en_cnt);
        check("post_rst_idcode", dout, 64'hDEB11001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ycr_tapc_os.md
Name: ycr_tapc_os

Overview:
- Oversampled IEEE 1149.1 TAP controller running entirely on the core clock.
- Sits directly upstream of the Debug Module Interface and drives its chain interface: chain select, chain ID, capture, shift, update, TDI; it consumes the DMI chain TDO.
- JTAG pins are pre-synchronised to clk outside this block.
- Contains the 16-state TAP FSM, a 5-bit IR, and internal IDCODE and BYPASS registers.

Parameters:
- YCR_TAP_IDCODE, 32'hDEB11001, value loaded into the IDCODE DR at Capture-DR; bit0 must be 1.
- YCR_TAP_IR_WIDTH, 5, instruction register width; fixed, not for override.

Ports:
- clk  input  1  core clock.
- rst  input  1  reset, synchronous, active-high.
- tck_sync_i  input  1  TCK, already synchronised to clk.
- tms_sync_i  input  1  TMS, synchronised.
- tdi_sync_i  input  1  TDI, synchronised.
- tdo_o  output  1  registered TDO.
- tdo_en_o  output  1  TDO output enable; high in Shift-DR/Shift-IR only.
- tapc2dmi_ch_sel_o  output  1  IR selects a DTM chain.
- tapc2dmi_ch_id_o  output  2  1 = DTMCS, 2 = DMI_ACCESS, 0 = none.
- tapc2dmi_ch_capture_o  output  1  one-clk capture pulse.
- tapc2dmi_ch_shift_o  output  1  one-clk shift pulse.
- tapc2dmi_ch_update_o  output  1  one-clk update pulse.
- tapc2dmi_ch_tdi_o  output  1  TDI forwarded to chain; equals tdi_sync_i sampled on the shift pulse.
- dmi2tapc_ch_tdo_i  input  1  chain TDO, i.e. bit0 of the DMI shift register.

Behaviour:
- Edge detect:
  - tck_q <= tck_sync_i.
  - rise = tck_sync_i & ~tck_q; fall = ~tck_sync_i & tck_q.
  - TCK high and low phases must each be ≥2 clk. Nothing is guaranteed for shorter phases.
- FSM: the 16 standard TAP states. The state advances only in a rise cycle, on tms_sync_i, per the IEEE 1149.1 transition table.
- Reset (rst=1 at posedge clk) sets:
  - state = Test-Logic-Reset, ir_ff = IDCODE, ir_shift = 0, idcode_sr = 0, bypass_ff = 0, tck_q = 0.
  - Outputs: tdo_o = 0, tdo_en_o = 0, all pulses 0, ch_sel = 0, ch_id = 0.
  - Reset mid-scan aborts the scan; no update pulse is issued.
- Test-Logic-Reset state: ir_ff forced to IDCODE each cycle.
- Five consecutive rise edges with TMS=1 reach Test-Logic-Reset from any state.
- Instruction decode:
  - 5'h01 IDCODE, 5'h10 DTMCS, 5'h11 DMI_ACCESS, 5'h1F BYPASS.
  - Any other value behaves as BYPASS.
- Chain outputs:
  - ch_sel_o = (ir_ff == DTMCS or DMI_ACCESS).
  - ch_id_o = 1 for DTMCS, 2 for DMI_ACCESS, else 0.
  - Both are combinational from ir_ff and are stable throughout a DR scan.
- IR actions:
  - rise in Capture-IR: ir_shift = 5'b00001.
  - rise in Shift-IR: ir_shift = {tdi, ir_shift[4:1]}.
  - fall in Update-IR: ir_ff = ir_shift.
- DR actions, in the rise cycle, evaluated on the state before the transition:
  - Capture-DR: idcode_sr = YCR_TAP_IDCODE; bypass_ff = 0; capture pulse if ch_sel.
  - Shift-DR: idcode_sr = {tdi, idcode_sr[31:1]}; bypass_ff = tdi; shift pulse if ch_sel.
  - Update-DR: update pulse issued in the fall cycle while in Update-DR, if ch_sel.
  - Every pulse is exactly 1 clk wide. The DMI samples the pulses on the same clk edge.
- TDO, registered in fall cycles only:
  - Shift-IR: tdo_o = ir_shift[0].
  - Shift-DR: tdo_o = idcode_sr[0] (IDCODE), bypass_ff (BYPASS/unknown), or dmi2tapc_ch_tdo_i (ch_sel).
  - tdo_en_o = 1 in Shift-IR/Shift-DR, else 0, updated in the same fall cycle.
  - The fall edge follows a rise edge by ≥2 clk, so the DMI's shift register has settled.
- Simultaneous events: rst wins over everything. rise and fall cannot occur in the same cycle.

Test Plan:
- Reset, then 5 TCK cycles with TMS=1 → state Test-Logic-Reset, ir_ff = 5'h01, ch_sel_o = 0, ch_id_o = 0, tdo_en_o = 0.
- From Run-Test/Idle, DR scan of 32 bits under IDCODE → tdo_o bits read LSB-first = 32'hDEB11001; tdo_en_o high only during the shifts.
- IR scan loading 5'h11 → captured IR shifted out = 5'b00001; after Update-IR, ch_sel_o = 1 and ch_id_o = 2.
- Then a 41-bit DR scan → exactly 1 capture pulse, 41 shift pulses, 1 update pulse, each 1 clk wide; ch_tdi_o matches the TDI stream; tdo_o mirrors dmi2tapc_ch_tdo_i.
- IR = 5'h05 (undefined), shift 8 bits 0xA5 → same pattern appears on tdo_o delayed by 1 TCK; ch_sel_o = 0; no chain pulses.
- rst asserted in the middle of a Shift-DR under DMI_ACCESS → next clk: state Test-Logic-Reset, ir_ff = IDCODE, no update pulse, all outputs at their reset values.
